// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings and FSM states.
package load_store_unit_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;
    localparam logic [2:0] FUNCT3_SB  = 3'd0;
    localparam logic [2:0] FUNCT3_SH  = 3'd1;
    localparam logic [2:0] FUNCT3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane logic: store lane mask and data replication,
// load lane extraction with sign/zero extension, and access legality.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  store_mask,
    output logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        error
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Store: replicate the datum across the word so any lane sees its bytes.
    always_comb begin
        store_mask = 4'b0000;
        store_data = 32'h0;
        case (funct3)
            FUNCT3_SB: begin
                store_data = {4{wdata[7:0]}};
                store_mask = 4'b0001 << addr_lo;
            end
            FUNCT3_SH: begin
                store_data = {2{wdata[15:0]}};
                store_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            FUNCT3_SW: begin
                store_data = wdata;
                store_mask = 4'b1111;
            end
            default: ;
        endcase
    end

    // Load: pick the addressed byte/half and extend to 32 bits.
    always_comb begin
        case (addr_lo)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = 32'h0;
        case (funct3)
            FUNCT3_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
            FUNCT3_LH:  load_data = {{16{lane_half[15]}}, lane_half};
            FUNCT3_LW:  load_data = rdata;
            FUNCT3_LBU: load_data = {24'h0, lane_byte};
            FUNCT3_LHU: load_data = {16'h0, lane_half};
            default:    load_data = 32'h0;
        endcase
    end

    // Misaligned halves/words and unused funct3 encodings are rejected.
    always_comb begin
        error = 1'b0;
        if (write) begin
            case (funct3)
                FUNCT3_SB: error = 1'b0;
                FUNCT3_SH: error = addr_lo[0];
                FUNCT3_SW: error = |addr_lo;
                default:   error = 1'b1;
            endcase
        end else begin
            case (funct3)
                FUNCT3_LB, FUNCT3_LBU: error = 1'b0;
                FUNCT3_LH, FUNCT3_LHU: error = addr_lo[0];
                FUNCT3_LW:             error = |addr_lo;
                default:               error = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time and runs a single
// word-aligned access on memory_bus, returning one response pulse.
//
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | bus strobe cycle (stores write here)
//   WAIT   | load waiting READ_LATENCY cycles for bus_data_in
//   RESP   | rsp_valid pulse; back to IDLE next cycle
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [31:0]           bus_data_out,
    output logic [3:0]            bus_write_mask,
    output logic                  bus_enable,
    output logic                  bus_write_enable,
    input  logic [31:0]           bus_data_in
);

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    lsu_state_e  st;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [1:0]  lat_cnt;

    logic        al_write;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_mask;
    logic [31:0] al_store_data;
    logic [31:0] al_load_data;
    logic        al_error;

    // Lane logic sees the live request while idle, the captured one afterwards.
    assign al_write   = (st == ST_IDLE) ? req_write             : r_write;
    assign al_funct3  = (st == ST_IDLE) ? req_funct3            : r_funct3;
    assign al_addr_lo = (st == ST_IDLE) ? req_address[1:0]      : r_addr_lo;

    load_store_unit_align u_align (
        .write      (al_write),
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .wdata      (req_wdata),
        .rdata      (bus_data_in),
        .store_mask (al_mask),
        .store_data (al_store_data),
        .load_data  (al_load_data),
        .error      (al_error)
    );

    // Sequencing FSM with registered bus and response outputs.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            st               <= ST_IDLE;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_error        <= 1'b0;
            rsp_rdata        <= 32'h0;
            bus_enable       <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_write_mask   <= 4'b0000;
            bus_address      <= '0;
            bus_data_out     <= 32'h0;
            r_write          <= 1'b0;
            r_funct3         <= 3'd0;
            r_addr_lo        <= 2'd0;
            lat_cnt          <= 2'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= 32'h0;
            case (st)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_write   <= req_write;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_address[1:0];
                        if (al_error) begin
                            st        <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                        end else begin
                            st          <= ST_ACCESS;
                            bus_enable  <= 1'b1;
                            bus_address <= {req_address[ADDR_WIDTH-1:2], 2'b00};
                            if (req_write) begin
                                bus_write_enable <= 1'b1;
                                bus_write_mask   <= al_mask;
                                bus_data_out     <= al_store_data;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_write) begin
                        st               <= ST_RESP;
                        rsp_valid        <= 1'b1;
                        bus_enable       <= 1'b0;
                        bus_write_enable <= 1'b0;
                        bus_write_mask   <= 4'b0000;
                        bus_address      <= '0;
                        bus_data_out     <= 32'h0;
                    end else begin
                        st      <= ST_WAIT;
                        lat_cnt <= LAT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        st          <= ST_RESP;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= al_load_data;
                        bus_enable  <= 1'b0;
                        bus_address <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    st        <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
